// File: rtl/serial_tx_shifter.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits, stop bit.
// Every output is decoded from registered state, so reset clears the line at once.
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             head;

  assign head = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    sout    = 1'b1;
    ready   = 1'b0;
    frame   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          accept  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        sout    = 1'b0;
        state_n = DATA;
      end
      DATA: begin
        sout  = head;
        frame = 1'b1;
        if (cnt == LAST) begin
          state_n = STOP;
        end
      end
      STOP: begin
        ready = 1'b1;
        done  = 1'b1;
        if (load) begin
          accept  = 1'b1;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Counter is held at zero outside DATA, so each frame starts counting fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        sh <= data_in;
      end else if (state == DATA) begin
        if (MSB_FIRST != 0) begin
          sh <= sh << 1;
        end else begin
          sh <= sh >> 1;
        end
      end
      if (state == DATA) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: 8-bit MSB-first and 4-bit LSB-first
// instances checked against a bit-list frame model.
module tb_serial_tx_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       ready;
  logic       sout;
  logic       frame;
  logic       done;

  logic       reset_b;
  logic       load_b;
  logic [3:0] data_b;
  logic       ready_b;
  logic       sout_b;
  logic       frame_b;
  logic       done_b;

  int total = 0;
  int bad   = 0;
  bit q[$];

  always #5 clk = ~clk;

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .sout    (sout),
    .frame   (frame),
    .done    (done)
  );

  serial_tx_shifter #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .data_in (data_b),
    .load    (load_b),
    .ready   (ready_b),
    .sout    (sout_b),
    .frame   (frame_b),
    .done    (done_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line contents for one frame: 0, data bits in send order, 1
  function automatic void model(input logic [31:0] w, input int width,
                                input bit msb);
    q.delete();
    q.push_back(1'b0);
    for (int i = 0; i < width; i++) begin
      q.push_back(msb ? w[width-1-i] : w[i]);
    end
    q.push_back(1'b1);
  endfunction

  task automatic idle_a(input string tag);
    check({tag, "_sout"}, sout, 1);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_frame"}, frame, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Caller drives load=1 with data_in=w before calling
  task automatic frame_a(input logic [7:0] w, input bit b2b,
                         input logic [7:0] nw, input bit noise,
                         input logic [7:0] nz);
    model({24'd0, w}, 8, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick;
      check($sformatf("a%02h_sout%0d", w, c), sout, q[c]);
      check($sformatf("a%02h_frame%0d", w, c), frame, (c >= 1 && c <= 8));
      check($sformatf("a%02h_done%0d", w, c), done, (c == 9));
      check($sformatf("a%02h_ready%0d", w, c), ready, (c == 9));
      if (c < 8) begin
        load = noise;
        if (noise) data_in = nz;
      end else if (c == 8) begin
        load = 1'b0;
      end else begin
        load = b2b;
        if (b2b) data_in = nw;
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] nw;
    logic [3:0] wb;
    bit         b;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    reset_b = 1'b1;
    load_b  = 1'b0;
    data_b  = 4'h0;

    for (int i = 0; i < 5; i++) begin
      tick;
      idle_a($sformatf("rst%0d", i));
      load    = ~load;
      data_in = 8'($urandom);
    end
    load    = 1'b0;
    reset   = 1'b0;
    reset_b = 1'b0;
    tick;
    idle_a("post_rst");

    load    = 1'b1;
    data_in = 8'hA5;
    frame_a(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    tick;
    idle_a("a5_after");

    load    = 1'b1;
    data_in = 8'h3C;
    frame_a(8'h3C, 1'b1, 8'hC3, 1'b0, 8'h00);
    frame_a(8'hC3, 1'b0, 8'h00, 1'b0, 8'h00);
    tick;
    idle_a("b2b_after");

    load    = 1'b1;
    data_in = 8'hFF;
    frame_a(8'hFF, 1'b0, 8'h00, 1'b1, 8'h00);
    tick;
    idle_a("busy_after1");
    tick;
    idle_a("busy_after2");

    load    = 1'b1;
    data_in = 8'hA5;
    model(32'hA5, 8, 1'b1);
    for (int c = 0; c <= 4; c++) begin
      tick;
      check($sformatf("abort_sout%0d", c), sout, q[c]);
      load = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    idle_a("abort_async");
    for (int i = 0; i < 3; i++) begin
      tick;
      idle_a($sformatf("abort_hold%0d", i));
    end
    reset = 1'b0;
    tick;
    idle_a("abort_rel");
    load    = 1'b1;
    data_in = 8'h81;
    frame_a(8'h81, 1'b0, 8'h00, 1'b0, 8'h00);
    tick;
    idle_a("r81_after");

    w       = 8'($urandom);
    load    = 1'b1;
    data_in = w;
    for (int i = 0; i < 6; i++) begin
      nw = 8'($urandom);
      b  = (i < 5) && ($urandom_range(0, 1) == 1);
      frame_a(w, b, nw, (i == 3), 8'($urandom));
      if (!b) begin
        tick;
        idle_a($sformatf("rnd_idle%0d", i));
        if (i < 5) begin
          load    = 1'b1;
          data_in = nw;
        end
      end
      w = nw;
    end

    for (int k = 0; k < 3; k++) begin
      wb      = (k == 0) ? 4'b0011 : 4'($urandom);
      load_b  = 1'b1;
      data_b  = wb;
      model({28'd0, wb}, 4, 1'b0);
      for (int c = 0; c < 6; c++) begin
        tick;
        check($sformatf("b%0h_sout%0d", wb, c), sout_b, q[c]);
        check($sformatf("b%0h_frame%0d", wb, c), frame_b, (c >= 1 && c <= 4));
        check($sformatf("b%0h_done%0d", wb, c), done_b, (c == 5));
        check($sformatf("b%0h_ready%0d", wb, c), ready_b, (c == 5));
        load_b = 1'b0;
      end
      tick;
      check($sformatf("b%0h_idle_sout", wb), sout_b, 1);
      check($sformatf("b%0h_idle_ready", wb), ready_b, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
# serial_tx_shifter

Parallel-to-serial frame transmitter that drives a single-bit serial line sampled one bit per clock by a downstream D flip-flop receiver. It accepts a WIDTH-bit word through a ready/load handshake and emits a framed bit stream: start bit, data bits, stop bit. It is the transmitting end of the team's serial capture path and replaces hand-written bench stimulus with a synthesizable source.

## Interface
- WIDTH, default 8: data word width. Legal range 2..32.
- MSB_FIRST, default 1: 1 sends data_in[WIDTH-1] first; 0 sends data_in[0] first.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit data_in; accepted on a rising edge where ready=1.
- ready  output  1  block can accept load this cycle.
- sout  output  1  serial line; idles high.
- frame  output  1  high exactly while a data bit is on sout.
- done  output  1  one-cycle pulse during the stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: sout=1, ready=1, frame=0, done=0. load=1 -> latch data_in into the shift register, go to START.
- START: sout=0, ready=0. Next state is DATA with bit counter = 0.
- DATA: sout = current shift-register output bit (MSB or LSB per MSB_FIRST), frame=1, ready=0. Shift once per cycle and increment the counter. After WIDTH cycles (counter = WIDTH-1), go to STOP.
- STOP: sout=1, done=1, ready=1.
  - load=1 -> latch data_in, go to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- load while ready=0 is ignored. No queueing, no error flag. data_in changes while not accepted have no effect.
- Bit counter width is $clog2(WIDTH). It does not wrap within a frame and resets to 0 on entering DATA.
- Reset values, applied asynchronously: state=IDLE, sout=1, ready=1, frame=0, done=0, shift register=0, counter=0.
- Reset mid-frame aborts the frame immediately: sout returns high in the same cycle, with no partial stop bit. The first load after reset deasserts starts a fresh frame.
- All outputs are registered or decoded from registered state only. No combinational path from load or data_in to any output.

## Timing
- Frame length is WIDTH+2 cycles: 1 start, WIDTH data, 1 stop.
- Latency: load accepted at edge N -> sout=0 (start) from edge N through N+1.
  - First data bit appears after edge N+1.
  - Last data bit appears after edge N+WIDTH.
  - Stop bit and done appear after edge N+WIDTH+1.
- Back-to-back: load accepted in STOP puts the next start bit right after the stop cycle. Throughput is one word per WIDTH+2 cycles.
- ready=1 only in IDLE and STOP. ready falls the cycle after acceptance.
- done is high for exactly one cycle per completed frame. It is never asserted for a frame aborted by reset.
- A downstream DFF sampling sout on the rising edge sees each bit exactly once.

## Test plan
- Reset: hold reset=1 for 5 cycles with load toggling -> sout=1, ready=1, frame=0, done=0 throughout. Assert reset asynchronously between edges -> outputs reach reset values before the next edge.
- Single word, WIDTH=8, MSB_FIRST=1, data_in=8'hA5, load for one cycle:
  - sout sequence 0,1,0,1,0,0,1,0,1,1.
  - frame high for exactly 8 cycles.
  - done pulses once, in the 10th cycle.
  - ready returns to 1 in the stop cycle.
- Back-to-back: load 8'h3C, then hold load=1 with data_in=8'hC3 through the STOP cycle:
  - sout is 0,00111100,1,0,11000011,1 with no idle cycle between frames.
  - done pulses twice, 10 cycles apart.
- Busy ignore: load 8'hFF, then assert load with data_in=8'h00 during DATA -> transmitted bits are all 1s and exactly one frame is sent.
- Reset mid-frame: assert reset during the 4th data bit of 8'hA5 -> sout=1 immediately, no done pulse. A new load of 8'h81 after release gives a clean frame 0,10000001,1.
- LSB-first, MSB_FIRST=0, WIDTH=4, data_in=4'b0011 -> sout 0,1,1,0,0,1 with frame high for 4 cycles.
